// File: rtl/key_pkg.sv
// Shared constants for the key debouncer: default qualification time and
// stability counter sizing.
package key_pkg;

    localparam int CLK_HZ      = 50_000_000;
    localparam int DEBOUNCE_MS = 10;

    localparam int DEBOUNCE_CYCLES_DEF = (CLK_HZ / 1000) * DEBOUNCE_MS;

    // Counter must be able to hold DEBOUNCE_CYCLES-1; one spare value keeps
    // the width sane for the smallest legal setting of 2.
    function automatic int cnt_width(input int cycles);
        return $clog2(cycles + 1);
    endfunction

    localparam int CNT_W_DEF = cnt_width(DEBOUNCE_CYCLES_DEF);

endpackage

// File: rtl/key_debounce_cell.sv
// One key channel: two-flop synchroniser, stability counter, debounced level,
// press/release strobes and a sticky press flag.
module key_debounce_cell
    import key_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n_raw,
    input  logic event_clr,
    output logic key_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic press_event
);

    localparam int               CNT_W    = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_meta;
    logic             sync_stable;
    logic             sampled;
    logic             accept;
    logic [CNT_W-1:0] cnt;

    assign sampled = ~sync_stable;
    assign accept  = (sampled != key_level) && (cnt == CNT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_meta     <= 1'b1;
            sync_stable   <= 1'b1;
            cnt           <= '0;
            key_level     <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            press_event   <= 1'b0;
        end else begin
            sync_meta   <= key_n_raw;
            sync_stable <= sync_meta;

            // Any sample agreeing with the current level discards progress.
            if (sampled == key_level || accept)
                cnt <= '0;
            else
                cnt <= cnt + CNT_W'(1);

            if (accept)
                key_level <= sampled;

            press_pulse   <= accept & sampled;
            release_pulse <= accept & ~sampled;

            // Set from the registered strobe so a clear in the strobe cycle loses.
            press_event <= press_pulse | (press_event & ~event_clr);
        end
    end

endmodule

// File: rtl/key_debouncer.sv
// Debounces the board's active-low push-buttons into clean active-high levels,
// edge strobes and software-acknowledged press flags, ahead of the button PIO.
module key_debouncer
    import key_pkg::*;
#(
    parameter int NUM_KEYS        = 3,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic [NUM_KEYS-1:0] key_n_raw,
    input  logic [NUM_KEYS-1:0] event_clr,
    output logic [NUM_KEYS-1:0] key_level,
    output logic [NUM_KEYS-1:0] press_pulse,
    output logic [NUM_KEYS-1:0] release_pulse,
    output logic [NUM_KEYS-1:0] press_event
);

    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
        key_debounce_cell #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_cell (
            .clk          (Clk),
            .rst          (Reset),
            .key_n_raw    (key_n_raw[k]),
            .event_clr    (event_clr[k]),
            .key_level    (key_level[k]),
            .press_pulse  (press_pulse[k]),
            .release_pulse(release_pulse[k]),
            .press_event  (press_event[k])
        );
    end

endmodule

// File: tb/tb_key_debouncer.sv
// Bench for key_debouncer: table vectors, directed corner sequences and
// randomized key activity against a sliding-window reference model.
module tb_key_debouncer;

    localparam int NK = 3;
    localparam int DC = 4;

    logic          Clk = 1'b0;
    logic          Reset;
    logic [NK-1:0] key_n_raw;
    logic [NK-1:0] event_clr;
    logic [NK-1:0] key_level;
    logic [NK-1:0] press_pulse;
    logic [NK-1:0] release_pulse;
    logic [NK-1:0] press_event;

    always #5 Clk = ~Clk;

    key_debouncer #(
        .NUM_KEYS       (NK),
        .DEBOUNCE_CYCLES(DC)
    ) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .key_n_raw    (key_n_raw),
        .event_clr    (event_clr),
        .key_level    (key_level),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .press_event  (press_event)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: raw samples reach the qualifier two edges late; a level
    // is accepted once the last DC samples since the previous accept all disagree.
    logic [NK-1:0] m_lvl, m_pp, m_rp, m_ev;
    bit            rq   [NK][$];
    bit            hist [NK][$];

    function automatic void model_reset();
        m_lvl = '0; m_pp = '0; m_rp = '0; m_ev = '0;
        for (int k = 0; k < NK; k++) begin
            rq[k].delete();
            rq[k].push_back(1'b1);
            rq[k].push_back(1'b1);
            hist[k].delete();
        end
    endfunction

    function automatic void model_edge();
        logic [NK-1:0] pp_n, rp_n, ev_n;
        bit s, all_diff;
        if (Reset) begin
            model_reset();
            return;
        end
        for (int k = 0; k < NK; k++) begin
            s = ~rq[k].pop_front();
            rq[k].push_back(key_n_raw[k]);
            pp_n[k] = 1'b0;
            rp_n[k] = 1'b0;
            ev_n[k] = m_pp[k] | (m_ev[k] & ~event_clr[k]);
            hist[k].push_back(s);
            if (hist[k].size() > DC) void'(hist[k].pop_front());
            all_diff = (hist[k].size() == DC);
            for (int i = 0; i < hist[k].size(); i++)
                if (hist[k][i] == m_lvl[k]) all_diff = 1'b0;
            if (all_diff) begin
                m_lvl[k] = s;
                pp_n[k]  = s;
                rp_n[k]  = ~s;
                hist[k].delete();
            end
        end
        m_pp = pp_n;
        m_rp = rp_n;
        m_ev = ev_n;
    endfunction

    task automatic compare_model(input string tag);
        vectors++;
        if ({key_level, press_pulse, release_pulse, press_event} !== {m_lvl, m_pp, m_rp, m_ev}) begin
            miscompares++;
            $display("FAIL %s @%0t: got lvl=%b pp=%b rp=%b ev=%b, want lvl=%b pp=%b rp=%b ev=%b",
                     tag, $time, key_level, press_pulse, release_pulse, press_event,
                     m_lvl, m_pp, m_rp, m_ev);
        end
    endtask

    task automatic tick(input string tag);
        @(posedge Clk);
        model_edge();
        @(negedge Clk);
        compare_model(tag);
    endtask

    task automatic chk(input string name, input logic [NK-1:0] act, input logic [NK-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s @%0t: got %b, want %b", name, $time, act, exp);
        end
    endtask

    typedef struct {
        logic [NK-1:0] raw;
        logic [NK-1:0] clr;
        int            n;
        logic [NK-1:0] lvl;
        logic [NK-1:0] pp;
        logic [NK-1:0] rp;
        logic [NK-1:0] ev;
    } vec_t;

    vec_t tbl[10];

    initial begin
        tbl[0] = '{3'b111, 3'b000, 3, 3'b000, 3'b000, 3'b000, 3'b000};
        tbl[1] = '{3'b110, 3'b000, 6, 3'b001, 3'b001, 3'b000, 3'b000};
        tbl[2] = '{3'b110, 3'b000, 1, 3'b001, 3'b000, 3'b000, 3'b001};
        tbl[3] = '{3'b110, 3'b001, 1, 3'b001, 3'b000, 3'b000, 3'b000};
        tbl[4] = '{3'b111, 3'b000, 5, 3'b001, 3'b000, 3'b000, 3'b000};
        tbl[5] = '{3'b111, 3'b000, 1, 3'b000, 3'b000, 3'b001, 3'b000};
        tbl[6] = '{3'b000, 3'b000, 6, 3'b111, 3'b111, 3'b000, 3'b000};
        tbl[7] = '{3'b000, 3'b010, 1, 3'b111, 3'b000, 3'b000, 3'b111};
        tbl[8] = '{3'b000, 3'b010, 1, 3'b111, 3'b000, 3'b000, 3'b101};
        tbl[9] = '{3'b111, 3'b000, 6, 3'b000, 3'b000, 3'b111, 3'b101};

        Reset     = 1'b1;
        key_n_raw = '1;
        event_clr = '0;
        model_reset();
        tick("reset");
        tick("reset");
        chk("reset_level", key_level, 3'b000);
        chk("reset_event", press_event, 3'b000);
        Reset = 1'b0;

        for (int r = 0; r < 10; r++) begin
            key_n_raw = tbl[r].raw;
            event_clr = tbl[r].clr;
            repeat (tbl[r].n) tick("table");
            chk($sformatf("tbl%0d_lvl", r), key_level, tbl[r].lvl);
            chk($sformatf("tbl%0d_pp", r), press_pulse, tbl[r].pp);
            chk($sformatf("tbl%0d_rp", r), release_pulse, tbl[r].rp);
            chk($sformatf("tbl%0d_ev", r), press_event, tbl[r].ev);
        end

        // Acknowledge everything, then bounce key 2 short of qualification.
        key_n_raw = '1;
        event_clr = '1;
        tick("clear_all");
        chk("clear_all_ev", press_event, 3'b000);
        event_clr = '0;
        begin
            bit pat [14] = '{0, 0, 0, 1, 0, 0, 0, 1, 1, 1, 1, 1, 1, 1};
            for (int i = 0; i < 14; i++) begin
                key_n_raw = {pat[i], 2'b11};
                tick("bounce");
                chk("bounce_key2", {key_level[2], press_pulse[2], press_event[2]}, 3'b000);
            end
        end

        // Key 0 held: qualify, then async reset mid-cycle for two edges.
        key_n_raw = 3'b110;
        repeat (8) tick("hold_k0");
        chk("hold_k0_lvl", key_level, 3'b001);
        #2 Reset = 1'b1;
        model_reset();
        #1;
        chk("async_rst_lvl", key_level, 3'b000);
        chk("async_rst_pp", press_pulse, 3'b000);
        chk("async_rst_rp", release_pulse, 3'b000);
        chk("async_rst_ev", press_event, 3'b000);
        tick("in_reset");
        tick("in_reset");
        Reset = 1'b0;
        repeat (5) tick("requalify");
        chk("requal_edge5_lvl", key_level, 3'b000);
        tick("requalify");
        chk("requal_edge6_lvl", key_level, 3'b001);
        chk("requal_edge6_pp", press_pulse, 3'b001);
        tick("requalify");
        chk("requal_edge7_pp", press_pulse, 3'b000);
        chk("requal_edge7_ev", press_event, 3'b001);

        // Randomized activity against the model.
        for (int c = 0; c < 600; c++) begin
            for (int k = 0; k < NK; k++)
                if ($urandom_range(0, 9) == 0) key_n_raw[k] = ~key_n_raw[k];
            for (int k = 0; k < NK; k++)
                event_clr[k] = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 149) == 0) begin
                Reset = 1'b1;
                model_reset();
                tick("rand_reset");
                Reset = 1'b0;
            end else begin
                tick("random");
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/key_debouncer.md
Name: key_debouncer

Overview:
- Conditions the raw active-low push-button lines on the board before they reach the processor's button PIO input.
- Per key:
  - synchronises the raw line into the system clock domain;
  - debounces it with a stability counter;
  - produces a clean active-high level, one-cycle press/release pulses, and a sticky press-event flag.
- Software can poll the sticky flag and acknowledge it with a clear strobe.
- Sits directly upstream of the button PIO, replacing the bare inversion of the key lines.

Parameters:
- NUM_KEYS, 3, number of independent key channels.
- DEBOUNCE_CYCLES, 500000, consecutive stable cycles required to accept a level change (10 ms at 50 MHz); must be >= 2.
- CNT_W, $clog2(DEBOUNCE_CYCLES+1), stability counter width (derived, not overridden).

Ports:
- Clk  input  1  system clock, 50 MHz.
- Reset  input  1  asynchronous, active-high reset.
- key_n_raw  input  NUM_KEYS  raw key lines, active-low, asynchronous to Clk.
- event_clr  input  NUM_KEYS  per-key clear strobe for press_event; one bit per key.
- key_level  output  NUM_KEYS  debounced key state, 1 = pressed.
- press_pulse  output  NUM_KEYS  one-cycle strobe on debounced press.
- release_pulse  output  NUM_KEYS  one-cycle strobe on debounced release.
- press_event  output  NUM_KEYS  sticky flag, set by press, cleared by event_clr.

Behaviour:
- One clock (Clk). Reset is asynchronous and active-high; all flops clear immediately on Reset assertion regardless of Clk.
- Reset values:
  - synchroniser flops = 1 (released, raw polarity);
  - counters = 0;
  - key_level = 0, press_pulse = 0, release_pulse = 0, press_event = 0.
- Synchroniser:
  - two flops per key; sync = second stage;
  - inverted to active-high: s = ~sync.
- Stability counter, per key, each cycle:
  - s == key_level: counter <= 0.
  - s != key_level and counter < DEBOUNCE_CYCLES-1: counter <= counter+1.
  - s != key_level and counter == DEBOUNCE_CYCLES-1: key_level <= s, counter <= 0.
- Latency:
  - a raw transition held steady is reflected on key_level exactly 2 + DEBOUNCE_CYCLES rising edges after it is sampled by the first sync flop;
  - any bounce returning to the old level before acceptance resets the counter to 0 (no partial credit).
- Pulses:
  - registered; press_pulse asserts in the same cycle key_level first reads 1, for exactly one cycle;
  - release_pulse is the same, for key_level first reading 0;
  - never both high on one key.
- press_event:
  - set when press_pulse fires; cleared when the event_clr bit is high;
  - simultaneous set and clear on the same key: set wins (the press is not lost);
  - event_clr with no pending event has no effect.
- Keys are fully independent; simultaneous activity on several keys causes no interaction.
- Reset mid-debounce:
  - counter and level are discarded;
  - after release, a key held pressed re-qualifies from scratch and produces a fresh press_pulse.
- Counter never exceeds DEBOUNCE_CYCLES-1; no wrap-around is possible.

Decomposition:
- Shared package key_pkg:
  - default DEBOUNCE_CYCLES value (CLK_HZ = 50_000_000, DEBOUNCE_MS = 10);
  - the derived count constant.
- Sub-module key_debounce_cell:
  - one key: synchroniser, counter, level, pulses, event flag;
  - parameterised by DEBOUNCE_CYCLES.
- key_debouncer instantiates NUM_KEYS cells in a generate loop.
- Top level drives the PIO from key_level of KEY[3:1] (or from press_event, as the software selects).

Test Plan (DEBOUNCE_CYCLES = 4, NUM_KEYS = 3):
- Reset asserted asynchronously mid-cycle with key 0 held low:
  - all outputs 0 immediately;
  - after deassert with key still low, key_level[0] rises on edge 6 and press_pulse[0] is high on edge 6 only.
- Clean press on key 1 (raw 1->0, held 20 cycles), then release (held 20 cycles):
  - key_level[1] = 1 at +6 edges, press_pulse[1] is a single-cycle pulse, press_event[1] = 1;
  - on release, key_level[1] = 0 at +6 edges with a single release_pulse[1].
- Bounce on key 2 (raw low 3 cycles, high 1, low 3, high):
  - key_level[2], press_pulse[2] and press_event[2] stay 0 throughout.
- press_event[0] pending, event_clr[0] pulsed one cycle:
  - press_event[0] reads 0 next cycle;
  - event_clr[0] asserted in the same cycle as a new press_pulse[0] leaves press_event[0] = 1.
- All three keys pressed on the same edge:
  - all three key_level bits rise together at +6;
  - pulses are coincident and single-cycle;
  - clearing key 1 only leaves press_event = 3'b101.
- Key 0 held pressed with Reset pulsed 2 cycles while key_level[0] = 1:
  - outputs clear during Reset;
  - key_level[0] re-asserts with a new press_pulse[0] 6 edges after Reset deasserts.
